// File: rtl/uart_tx_engine_if.sv
// Write-side bus of the UART transmitter: queue push port plus queue status.
// The register file acts as master; uart_tx_engine is the slave.
interface uart_tx_engine_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int QUEUE_DEPTH = 16
);
  localparam int LVL_W = $clog2(QUEUE_DEPTH) + 1;

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  full;
  logic                  empty;
  logic [LVL_W-1:0]      level;

  modport master (
    output wr_en, wr_data,
    input  full, empty, level
  );

  modport slave (
    input  wr_en, wr_data,
    output full, empty, level
  );
endinterface

// File: rtl/uart_tx_engine.sv
// UART transmitter: TX queue feeding a self-timed framing engine.
// Data length, parity and stop bits are latched per frame at pop time.
// Optional flow control: define UART_TX_CTS_EN to add the active-low
// clear-to-send input cts_n; a new frame then starts only when it is low.
module uart_tx_engine #(
  parameter int DATA_WIDTH  = 8,
  parameter int QUEUE_DEPTH = 16,
  parameter int DIV_WIDTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DIV_WIDTH-1:0]          divisor,
  input  logic [$clog2(DATA_WIDTH)-1:0] data_len,
  input  logic [1:0]                    parity_type,
  input  logic                          stop2,
`ifdef UART_TX_CTS_EN
  input  logic                          cts_n,
`endif
  uart_tx_engine_if.slave               bus,
  output logic                          tx,
  output logic                          busy
);

  localparam int LEN_W = $clog2(DATA_WIDTH);
  localparam int AW    = $clog2(QUEUE_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  // Queue storage and control
  logic [DATA_WIDTH-1:0] mem [QUEUE_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           level_q;
  logic                  push, pop;
  logic [DATA_WIDTH-1:0] rd_data;

  // Framing engine state
  state_t                state, state_d;
  logic [DIV_WIDTH-1:0]  cnt, cnt_d;
  logic [LEN_W-1:0]      bit_idx, bit_d;
  logic                  stop_idx, stop_d;
  logic                  tx_q, tx_d;
  logic                  tick, can_start, load, cts_ok;

  // Frame data and per-frame configuration
  logic [DATA_WIDTH-1:0] shreg, shreg_d;
  logic                  par_acc, par_acc_d;
  logic [DIV_WIDTH-1:0]  div_q;
  logic [LEN_W-1:0]      len_q, len_lo, len_eff;
  logic [1:0]            par_q;
  logic                  stop2_q;

  assign bus.full  = (level_q == (AW+1)'(QUEUE_DEPTH));
  assign bus.empty = (level_q == '0);
  assign bus.level = level_q;
  assign push      = bus.wr_en && !bus.full;
  assign rd_data   = mem[rd_ptr];

  // Short data lengths clamp to 5 bits; long ones to the datapath width.
  assign len_lo = (data_len < LEN_W'(4)) ? LEN_W'(4) : data_len;
  if (2**LEN_W > DATA_WIDTH) begin : g_len_hi
    assign len_eff = (len_lo > LEN_W'(DATA_WIDTH-1)) ? LEN_W'(DATA_WIDTH-1) : len_lo;
  end else begin : g_len_ok
    assign len_eff = len_lo;
  end

`ifdef UART_TX_CTS_EN
  logic cts_s1, cts_s2;

  // Two-flop synchroniser for the asynchronous clear-to-send pin
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cts_s1 <= 1'b1;
      cts_s2 <= 1'b1;
    end else begin
      cts_s1 <= cts_n;
      cts_s2 <= cts_s1;
    end
  end

  assign cts_ok = !cts_s2;
`else
  assign cts_ok = 1'b1;
`endif

  assign can_start = !bus.empty && cts_ok;
  assign tick      = (cnt == div_q);
  assign tx        = tx_q;
  assign busy      = (state != S_IDLE);

  // Queue storage write; contents need no reset since pointers gate reads
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.wr_data;
  end

  // Queue pointers and occupancy; a simultaneous push and pop keeps the level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Next-state, bit timing and serial output selection
  always_comb begin
    state_d   = state;
    cnt_d     = cnt + DIV_WIDTH'(1);
    bit_d     = bit_idx;
    stop_d    = stop_idx;
    tx_d      = tx_q;
    shreg_d   = shreg;
    par_acc_d = par_acc;
    load      = 1'b0;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        tx_d  = 1'b1;
        cnt_d = '0;
        if (can_start) begin
          pop       = 1'b1;
          load      = 1'b1;
          shreg_d   = rd_data;
          par_acc_d = 1'b0;
          state_d   = S_START;
          tx_d      = 1'b0;
        end
      end
      S_START: begin
        if (tick) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_DATA;
          tx_d    = shreg[0];
        end
      end
      S_DATA: begin
        if (tick) begin
          cnt_d     = '0;
          shreg_d   = shreg >> 1;
          par_acc_d = par_acc ^ shreg[0];
          if (bit_idx == len_q) begin
            if (par_q[1]) begin
              state_d = S_PARITY;
              tx_d    = par_acc ^ shreg[0] ^ par_q[0];
            end else begin
              state_d = S_STOP;
              stop_d  = 1'b0;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_idx + LEN_W'(1);
            tx_d  = shreg[1];
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          cnt_d   = '0;
          stop_d  = 1'b0;
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        if (tick) begin
          cnt_d = '0;
          if (stop_idx == stop2_q) begin
            if (can_start) begin
              // Chain straight into the next start bit with no idle gap
              pop       = 1'b1;
              load      = 1'b1;
              shreg_d   = rd_data;
              par_acc_d = 1'b0;
              state_d   = S_START;
              tx_d      = 1'b0;
            end else begin
              state_d = S_IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // Engine control registers; reset forces the line idle immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      bit_idx  <= bit_d;
      stop_idx <= stop_d;
      tx_q     <= tx_d;
    end
  end

  // Frame data and configuration snapshot, loaded whenever a word is popped
  always_ff @(posedge clk) begin
    shreg   <= shreg_d;
    par_acc <= par_acc_d;
    if (load) begin
      div_q   <= divisor;
      len_q   <= len_eff;
      par_q   <= parity_type;
      stop2_q <= stop2;
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: directed writes push hand-computed frame bit
// patterns into a scoreboard; a serial monitor on tx pops and compares.
// Define UART_TX_CTS_EN to also exercise clear-to-send flow control.
module tb_uart_tx_engine;

  typedef struct {
    logic [31:0] bits;   // frame bits, bit 0 sent first (start bit)
    int          nbits;
    int          div;
  } frame_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] divisor;
  logic [2:0]  data_len;
  logic [1:0]  parity_type;
  logic        stop2;
  logic        tx;
  logic        busy;
`ifdef UART_TX_CTS_EN
  logic        cts_n;
`endif

  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  logic   mon_en = 1'b0;
  logic   mon_busy = 1'b0;
  frame_t exp_q[$];
  int     starts[$];

  uart_tx_engine_if #(.DATA_WIDTH(8), .QUEUE_DEPTH(16)) bus ();

  uart_tx_engine #(.DATA_WIDTH(8), .QUEUE_DEPTH(16), .DIV_WIDTH(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .divisor     (divisor),
    .data_len    (data_len),
    .parity_type (parity_type),
    .stop2       (stop2),
`ifdef UART_TX_CTS_EN
    .cts_n       (cts_n),
`endif
    .bus         (bus),
    .tx          (tx),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] frame8n1(input logic [7:0] w);
    return 32'({1'b1, w, 1'b0});
  endfunction

  task automatic push_exp(input logic [31:0] bits, input int nbits);
    frame_t f;
    f.bits  = bits;
    f.nbits = nbits;
    f.div   = int'(divisor);
    exp_q.push_back(f);
  endtask

  task automatic write_word(input logic [7:0] w, input logic [31:0] bits, input int nbits);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_data = w;
    push_exp(bits, nbits);
    @(posedge clk);
    #1 bus.wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_busy || busy) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(n < max_cyc), 32'd1);
  endtask

  task automatic count_low(input int ncyc, output int lows);
    lows = 0;
    repeat (ncyc) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
  endtask

  // Serial monitor: detects a start bit, samples every cycle of the frame
  initial begin : monitor
    frame_t      e;
    logic [31:0] cap;
    logic        stable;
    logic        aborted;
    forever begin
      @(negedge clk);
      if (!mon_en || reset !== 1'b0 || tx !== 1'b0) continue;
      mon_busy = 1'b1;
      starts.push_back(cyc);
      chk("frame_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() == 0) begin
        for (int n = 0; n < 1000; n++) begin
          if (tx === 1'b1) break;
          @(negedge clk);
        end
        mon_busy = 1'b0;
        continue;
      end
      e       = exp_q.pop_front();
      cap     = '0;
      stable  = 1'b1;
      aborted = 1'b0;
      for (int i = 0; i < e.nbits; i++) begin
        for (int j = 0; j <= e.div; j++) begin
          if (i != 0 || j != 0) @(negedge clk);
          if (reset !== 1'b0) begin
            aborted = 1'b1;
            break;
          end
          if (j == 0) cap[i] = tx;
          else if (tx !== cap[i]) stable = 1'b0;
        end
        if (aborted) break;
      end
      if (!aborted) begin
        chk("frame_bits", cap, e.bits);
        chk("frame_bit_stable", 32'(stable), 32'd1);
      end
      mon_busy = 1'b0;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int n;
    int lows;
    int bad;
    reset       = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    divisor     = 16'd3;
    data_len    = 3'd7;
    parity_type = 2'b00;
    stop2       = 1'b0;
`ifdef UART_TX_CTS_EN
    cts_n       = 1'b0;
`endif
    #1 reset = 1'b1;
    #1;
    chk("reset_tx", tx, 1);
    chk("reset_busy", busy, 0);
    chk("reset_full", bus.full, 0);
    chk("reset_empty", bus.empty, 1);
    chk("reset_level", bus.level, 0);
    repeat (3) @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Basic 8N1 frame, divisor 3: 0xA5 -> 0,1,0,1,0,0,1,0,1,1
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'hA5;
    push_exp(32'h34A, 10);
    @(posedge clk);
    #1 bus.wr_en = 1'b0;
    chk("basic_empty_fall", bus.empty, 0);
    chk("basic_busy_before_pop", busy, 0);
    chk("basic_tx_before_pop", tx, 1);
    @(posedge clk);
    #1;
    chk("basic_tx_start", tx, 0);
    chk("basic_busy_rise", busy, 1);
    chk("basic_level_after_pop", bus.level, 0);
    n = 0;
    repeat (200) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    chk("basic_busy_cycles", n, 40);
    wait_idle(200, "basic_done");

    // Parity and length
    divisor     = 16'd1;
    parity_type = 2'b10;
    write_word(8'h07, 32'h60E, 11);
    wait_idle(200, "even_parity_done");
    parity_type = 2'b11;
    write_word(8'h07, 32'h40E, 11);
    wait_idle(200, "odd_parity_done");
    parity_type = 2'b00;
    data_len    = 3'd2;
    write_word(8'hFF, 32'h07E, 7);
    wait_idle(200, "len5_done");
    data_len    = 3'd7;

    // Full queue: 18 consecutive writes, 17 accepted, back-to-back frames
    divisor = 16'd9;
    starts.delete();
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (i == 1)  chk("fifo_level_first", bus.level, 1);
      if (i == 2)  chk("fifo_push_pop_level", bus.level, 1);
      if (i == 17) chk("fifo_full_at_18th", bus.full, 1);
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'(8'h40 + i);
      if (i < 17) push_exp(frame8n1(8'(8'h40 + i)), 10);
    end
    @(negedge clk);
    bus.wr_en = 1'b0;
    chk("fifo_drop_level", bus.level, 16);
    wait_idle(1900, "fifo_drain_done");
    chk("b2b_frame_count", starts.size(), 17);
    bad = 0;
    for (int i = 1; i < starts.size(); i++)
      if (starts[i] - starts[i-1] != 100) bad++;
    chk("b2b_frame_spacing", bad, 0);
    chk("fifo_end_empty", bus.empty, 1);
    chk("fifo_end_level", bus.level, 0);
    chk("fifo_end_busy", busy, 0);

    // Mid-frame configuration change only affects the next frame
    divisor = 16'd3;
    write_word(8'h3C, 32'h278, 10);
    write_word(8'h81, 32'hD02, 12);
    repeat (12) @(negedge clk);
    parity_type = 2'b10;
    stop2       = 1'b1;
    wait_idle(300, "midcfg_done");
    parity_type = 2'b00;
    stop2       = 1'b0;

    // Reset mid-frame with three words queued
    write_word(8'h11, frame8n1(8'h11), 10);
    write_word(8'h12, frame8n1(8'h12), 10);
    write_word(8'h13, frame8n1(8'h13), 10);
    write_word(8'h14, frame8n1(8'h14), 10);
    chk("rst_level_before", bus.level, 3);
    repeat (8) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_tx", tx, 1);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_level", bus.level, 0);
    chk("rst_mid_empty", bus.empty, 1);
    repeat (3) @(negedge clk);
    exp_q.delete();
    reset = 1'b0;
    count_low(100, lows);
    chk("rst_no_tx_after", lows, 0);
    chk("rst_busy_after", busy, 0);

`ifdef UART_TX_CTS_EN
    // Flow control: hold, release, and hold again between frames
    divisor = 16'd1;
    @(negedge clk);
    cts_n = 1'b1;
    repeat (4) @(negedge clk);
    write_word(8'h55, 32'h2AA, 10);
    write_word(8'h33, 32'h266, 10);
    count_low(20, lows);
    chk("cts_hold_tx_high", lows, 0);
    chk("cts_hold_level", bus.level, 2);
    @(negedge clk);
    cts_n = 1'b0;
    n = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      n++;
      if (tx === 1'b0) break;
    end
    chk("cts_start_latency", n, 3);
    repeat (6) @(negedge clk);
    cts_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("cts_second_held_level", bus.level, 1);
    chk("cts_second_held_busy", busy, 0);
    chk("cts_second_held_tx", tx, 1);
    cts_n = 1'b0;
    wait_idle(200, "cts_release_done");
`endif

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
